// File: rtl/transaccion_n_pkg.sv
// Shared definitions for the transaccion_n switch: FSM state encodings and
// default parameter values used by the top level and the bench.
package transaccion_n_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_WORD_SIZE  = 10;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_CNT_WIDTH  = 5;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

endpackage

// File: rtl/transaccion_n_fifo.sv
// Synchronous FIFO with power-of-two depth, async active-high reset, head-word
// lookahead and occupancy count. Push on full and pop on empty are ignored.
module fifo_n #(
    parameter int WORD_SIZE  = 10,
    parameter int FIFO_DEPTH = 8,
    localparam int PTR_SIZE  = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic [PTR_SIZE:0]    count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [PTR_SIZE:0] DEPTH_C = (PTR_SIZE+1)'(FIFO_DEPTH);

    logic [WORD_SIZE-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_SIZE-1:0]  wr_ptr_r;
    logic [PTR_SIZE-1:0]  rd_ptr_r;
    logic [PTR_SIZE:0]    count_r;
    logic                 do_push_s;
    logic                 do_pop_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == (PTR_SIZE+1)'(0));
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_SIZE'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_SIZE'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_SIZE+1)'(1);
                2'b01:   count_r <= count_r - (PTR_SIZE+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/transaccion_n.sv
// NUM_CH x NUM_CH word switch: input FIFOs drained by a round-robin arbiter into
// destination output FIFOs, with almost-full back-pressure and pop counters.
module transaccion_n
    import transaccion_n_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    localparam int PTR_SIZE  = $clog2(FIFO_DEPTH),
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic [PTR_SIZE-1:0]         almost_full_threshold,
    input  logic [PTR_SIZE-1:0]         almost_empty_threshold,
    input  logic [NUM_CH-1:0]           push_in,
    input  logic [NUM_CH*WORD_SIZE-1:0] data_in,
    input  logic [NUM_CH-1:0]           pop_out,
    input  logic                        req,
    input  logic [CH_W-1:0]             idx,
    output logic [NUM_CH*WORD_SIZE-1:0] data_out,
    output logic [NUM_CH-1:0]           empty_out,
    output logic [NUM_CH-1:0]           almost_empty_out,
    output logic [NUM_CH-1:0]           almost_full_out,
    output logic [NUM_CH-1:0]           full_in,
    output logic [NUM_CH-1:0]           error,
    output logic [CNT_WIDTH-1:0]        cnt_data,
    output logic                        cnt_valid,
    output logic [1:0]                  state
);

    state_t                state_r;
    state_t                state_next_s;
    logic [PTR_SIZE-1:0]   af_thr_r;
    logic [PTR_SIZE-1:0]   ae_thr_r;
    logic [PTR_SIZE:0]     af_level_s;
    logic [CH_W-1:0]       rr_ptr_r;
    logic [CH_W-1:0]       grant_s;
    logic [CH_W-1:0]       cand_s;
    logic                  grant_valid_s;
    logic                  in_pending_s;

    logic [WORD_SIZE-1:0]  in_head_s   [NUM_CH];
    logic [PTR_SIZE:0]     in_count_s  [NUM_CH];
    logic [CH_W-1:0]       dest_s      [NUM_CH];
    logic [NUM_CH-1:0]     in_full_s;
    logic [NUM_CH-1:0]     in_empty_s;
    logic [NUM_CH-1:0]     in_pop_s;
    logic [NUM_CH-1:0]     eligible_s;

    logic [WORD_SIZE-1:0]  out_head_s  [NUM_CH];
    logic [PTR_SIZE:0]     out_count_s [NUM_CH];
    logic [NUM_CH-1:0]     out_full_s;
    logic [NUM_CH-1:0]     out_empty_s;
    logic [NUM_CH-1:0]     out_af_s;
    logic [NUM_CH-1:0]     out_ae_s;
    logic [NUM_CH-1:0]     out_push_s;
    logic [NUM_CH-1:0]     out_pop_eff_s;
    logic [WORD_SIZE-1:0]  xfer_word_s;

    logic [WORD_SIZE-1:0]  data_out_r  [NUM_CH];
    logic [CNT_WIDTH-1:0]  cnt_r       [NUM_CH];
    logic [NUM_CH-1:0]     error_r;
    logic [CNT_WIDTH-1:0]  cnt_data_r;
    logic                  cnt_valid_r;

    assign af_level_s  = (PTR_SIZE+1)'(FIFO_DEPTH) - {1'b0, af_thr_r};
    assign xfer_word_s = in_head_s[grant_s];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fifo_n #(
            .WORD_SIZE  (WORD_SIZE),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_in_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_in[i]),
            .pop   (in_pop_s[i]),
            .wdata (data_in[i*WORD_SIZE +: WORD_SIZE]),
            .rdata (in_head_s[i]),
            .count (in_count_s[i]),
            .full  (in_full_s[i]),
            .empty (in_empty_s[i])
        );

        fifo_n #(
            .WORD_SIZE  (WORD_SIZE),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_out_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (out_push_s[i]),
            .pop   (pop_out[i]),
            .wdata (xfer_word_s),
            .rdata (out_head_s[i]),
            .count (out_count_s[i]),
            .full  (out_full_s[i]),
            .empty (out_empty_s[i])
        );

        assign dest_s[i]           = in_head_s[i][WORD_SIZE-1 -: CH_W];
        assign out_af_s[i]         = (out_count_s[i] >= af_level_s);
        assign out_ae_s[i]         = (out_count_s[i] <= {1'b0, ae_thr_r});
        assign out_pop_eff_s[i]    = pop_out[i] && !out_empty_s[i];
        assign data_out[i*WORD_SIZE +: WORD_SIZE] = data_out_r[i];
    end

    assign empty_out        = out_empty_s;
    assign almost_empty_out = out_ae_s;
    assign almost_full_out  = out_af_s;
    assign full_in          = in_full_s;
    assign error            = error_r;
    assign cnt_data         = cnt_data_r;
    assign cnt_valid        = cnt_valid_r;
    assign state            = state_r;

    // Eligibility, round-robin pick (lowest offset from rr_ptr wins) and routing strobes.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = '0;
        cand_s        = '0;
        in_pending_s  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible_s[i] = (state_r == ST_ACTIVE) && !in_empty_s[i] &&
                            !out_af_s[dest_s[i]] && !out_full_s[dest_s[i]];
            in_pending_s  = in_pending_s | (in_count_s[i] != (PTR_SIZE+1)'(0));
        end
        for (int k = NUM_CH-1; k >= 0; k--) begin
            cand_s = rr_ptr_r + CH_W'(k);
            if (eligible_s[cand_s]) begin
                grant_valid_s = 1'b1;
                grant_s       = cand_s;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            out_push_s[j] = grant_valid_s && (dest_s[grant_s] == CH_W'(j));
            in_pop_s[j]   = grant_valid_s && (grant_s == CH_W'(j));
        end
    end

    // Next-state logic; init has priority over traffic-driven transitions.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RESET: begin
                state_next_s = ST_INIT;
            end
            ST_INIT: begin
                if (init) state_next_s = ST_INIT;
                else      state_next_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (init)              state_next_s = ST_INIT;
                else if (in_pending_s) state_next_s = ST_ACTIVE;
                else                   state_next_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (init)               state_next_s = ST_INIT;
                else if (!in_pending_s) state_next_s = ST_IDLE;
                else                    state_next_s = ST_ACTIVE;
            end
            default: begin
                state_next_s = ST_RESET;
            end
        endcase
    end

    // Control state: FSM, thresholds (tracked while in INIT) and arbiter pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_RESET;
            af_thr_r <= '0;
            ae_thr_r <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_INIT) begin
                af_thr_r <= almost_full_threshold;
                ae_thr_r <= almost_empty_threshold;
            end
            if (grant_valid_s) begin
                rr_ptr_r <= grant_s + CH_W'(1);
            end
        end
    end

    // Datapath registers: popped words, pop counters, sticky overflow, counter readout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUM_CH; j++) begin
                data_out_r[j] <= '0;
                cnt_r[j]      <= '0;
            end
            error_r     <= '0;
            cnt_data_r  <= '0;
            cnt_valid_r <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (out_pop_eff_s[j]) begin
                    data_out_r[j] <= out_head_s[j];
                end
                if (state_r == ST_INIT) begin
                    cnt_r[j] <= '0;
                end else if (out_pop_eff_s[j]) begin
                    cnt_r[j] <= cnt_r[j] + CNT_WIDTH'(1);
                end
            end
            error_r     <= error_r | (push_in & in_full_s);
            cnt_valid_r <= req;
            cnt_data_r  <= req ? cnt_r[idx] : '0;
        end
    end

endmodule

// File: tb/tb_transaccion_n.sv
// Directed self-checking bench for transaccion_n: routing vector table plus
// hand-written sequences for arbitration order, back-pressure, overflow, wrap, reset.
module tb_transaccion_n;

    logic        clk;
    logic        reset;
    logic        init;
    logic [2:0]  almost_full_threshold;
    logic [2:0]  almost_empty_threshold;
    logic [3:0]  push_in;
    logic [39:0] data_in;
    logic [3:0]  pop_out;
    logic        req;
    logic [1:0]  idx;
    logic [39:0] data_out;
    logic [3:0]  empty_out;
    logic [3:0]  almost_empty_out;
    logic [3:0]  almost_full_out;
    logic [3:0]  full_in;
    logic [3:0]  error;
    logic [4:0]  cnt_data;
    logic        cnt_valid;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    transaccion_n #(
        .NUM_CH     (4),
        .WORD_SIZE  (10),
        .FIFO_DEPTH (8),
        .CNT_WIDTH  (5)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .init                   (init),
        .almost_full_threshold  (almost_full_threshold),
        .almost_empty_threshold (almost_empty_threshold),
        .push_in                (push_in),
        .data_in                (data_in),
        .pop_out                (pop_out),
        .req                    (req),
        .idx                    (idx),
        .data_out               (data_out),
        .empty_out              (empty_out),
        .almost_empty_out       (almost_empty_out),
        .almost_full_out        (almost_full_out),
        .full_in                (full_in),
        .error                  (error),
        .cnt_data               (cnt_data),
        .cnt_valid              (cnt_valid),
        .state                  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         src;
        logic [9:0] word;
        int         dst;
        logic [3:0] empty_exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] dout(input int j);
        return data_out[j*10 +: 10];
    endfunction

    task automatic send(input int ch, input logic [9:0] w);
        data_in[ch*10 +: 10] = w;
        push_in[ch] = 1'b1;
        cyc();
        push_in[ch] = 1'b0;
    endtask

    task automatic pop(input int j);
        pop_out[j] = 1'b1;
        cyc();
        pop_out[j] = 1'b0;
    endtask

    task automatic wait_nonempty(input int j, input string name);
        int n = 0;
        while (empty_out[j] && n < 20) begin
            cyc();
            n++;
        end
        check({name, "_arrival"}, 32'(empty_out[j]), 32'd0);
    endtask

    task automatic rd_cnt(input logic [1:0] i, input logic [4:0] exp, input string name);
        req = 1'b1;
        idx = i;
        cyc();
        req = 1'b0;
        check({name, "_valid"}, 32'(cnt_valid), 32'd1);
        check({name, "_data"}, 32'(cnt_data), 32'(exp));
        cyc();
        check({name, "_idle"}, 32'({cnt_valid, cnt_data}), 32'd0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_state"}, 32'(state), 32'd0);
        check({name, "_dout"}, 32'(data_out != 40'd0), 32'd0);
        check({name, "_empty"}, 32'(empty_out), 32'hF);
        check({name, "_ae"}, 32'(almost_empty_out), 32'hF);
        check({name, "_af"}, 32'(almost_full_out), 32'd0);
        check({name, "_fullin"}, 32'(full_in), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_cnt"}, 32'({cnt_valid, cnt_data}), 32'd0);
    endtask

    task automatic reset_init(input string name);
        reset = 1'b1;
        init = 1'b0;
        push_in = 4'd0;
        pop_out = 4'd0;
        req = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        init = 1'b1;
        almost_full_threshold = 3'd2;
        almost_empty_threshold = 3'd1;
        cyc();
        init = 1'b0;
        cyc();
        check({name, "_idle"}, 32'(state), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{0, 10'h2A5, 2, 4'b1011};
        vecs[1] = '{1, 10'h0FF, 0, 4'b1110};
        vecs[2] = '{2, 10'h13C, 1, 4'b1101};
        vecs[3] = '{3, 10'h3C3, 3, 4'b0111};
        vecs[4] = '{3, 10'h200, 2, 4'b1011};
        vecs[5] = '{1, 10'h1FF, 1, 4'b1101};

        reset = 1'b1;
        init = 1'b0;
        almost_full_threshold = 3'd0;
        almost_empty_threshold = 3'd0;
        push_in = 4'd0;
        data_in = 40'd0;
        pop_out = 4'd0;
        req = 1'b0;
        idx = 2'd0;
        #2;
        check_reset_vals("por");

        // Single-word routing table.
        reset_init("tbl");
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].src, vecs[v].word);
            wait_nonempty(vecs[v].dst, $sformatf("tbl%0d", v));
            check($sformatf("tbl%0d_empty", v), 32'(empty_out), 32'(vecs[v].empty_exp));
            pop(vecs[v].dst);
            check($sformatf("tbl%0d_data", v), 32'(dout(vecs[v].dst)), 32'(vecs[v].word));
            check($sformatf("tbl%0d_drained", v), 32'(empty_out), 32'hF);
        end
        rd_cnt(2'd2, 5'd2, "cnt2");
        rd_cnt(2'd0, 5'd1, "cnt0");
        rd_cnt(2'd1, 5'd2, "cnt1");
        rd_cnt(2'd3, 5'd1, "cnt3");

        // Four inputs to output 0 in the same cycle: round-robin order 0,1,2,3.
        reset_init("rr");
        for (int i = 0; i < 4; i++) data_in[i*10 +: 10] = 10'(i + 1);
        push_in = 4'hF;
        cyc();
        push_in = 4'h0;
        cyc();
        check("rr_active", 32'(state), 32'd3);
        cyc();
        check("rr_first_empty", 32'(empty_out[0]), 32'd0);
        check("rr_first_ae", 32'(almost_empty_out[0]), 32'd1);
        cyc();
        check("rr_second_ae", 32'(almost_empty_out[0]), 32'd0);
        cyc();
        cyc();
        check("rr_four_af", 32'(almost_full_out[0]), 32'd0);
        cyc();
        check("rr_back_idle", 32'(state), 32'd2);
        for (int i = 0; i < 4; i++) begin
            pop(0);
            check($sformatf("rr_order%0d", i), 32'(dout(0)), 32'(i + 1));
        end
        check("rr_all_empty", 32'(empty_out), 32'hF);

        // Almost-full back-pressure on output 1 fed from input 0.
        reset_init("bp");
        for (int k = 0; k < 10; k++) send(0, 10'h100 + 10'(k));
        check("bp_af", 32'(almost_full_out[1]), 32'd1);
        check("bp_fullin_lo", 32'(full_in[0]), 32'd0);
        check("bp_active", 32'(state), 32'd3);
        for (int k = 10; k < 14; k++) send(0, 10'h100 + 10'(k));
        check("bp_fullin_hi", 32'(full_in[0]), 32'd1);
        check("bp_no_error", 32'(error), 32'd0);
        pop(1);
        check("bp_pop_data", 32'(dout(1)), 32'h100);
        check("bp_af_released", 32'(almost_full_out[1]), 32'd0);
        check("bp_full_before_xfer", 32'(full_in[0]), 32'd1);
        cyc();
        check("bp_full_after_xfer", 32'(full_in[0]), 32'd0);
        check("bp_af_again", 32'(almost_full_out[1]), 32'd1);
        cyc();
        cyc();
        send(0, 10'h10E);
        check("bp_single_xfer", 32'(full_in[0]), 32'd1);
        for (int k = 1; k < 15; k++) begin
            wait_nonempty(1, $sformatf("bp_drain%0d", k));
            pop(1);
            check($sformatf("bp_drain%0d_data", k), 32'(dout(1)), 32'h100 + 32'(k));
        end
        check("bp_drained", 32'(empty_out[1]), 32'd1);
        pop(1);
        check("bp_empty_pop_hold", 32'(dout(1)), 32'h10E);
        rd_cnt(2'd1, 5'd15, "bp_cnt");
        init = 1'b1;
        cyc();
        init = 1'b0;
        cyc();
        rd_cnt(2'd1, 5'd0, "bp_cnt_cleared");

        // Overflow on input 3 while held in INIT (no transfers drain it).
        reset_init("ovf");
        init = 1'b1;
        cyc();
        for (int k = 0; k < 8; k++) send(3, 10'h300 + 10'(k));
        check("ovf_full", 32'(full_in[3]), 32'd1);
        check("ovf_no_err", 32'(error), 32'd0);
        send(3, 10'h3FF);
        check("ovf_err", 32'(error), 32'h8);
        init = 1'b0;
        cyc();
        wait_nonempty(3, "ovf_release");
        check("ovf_err_sticky", 32'(error), 32'h8);
        pop(3);
        check("ovf_first_word", 32'(dout(3)), 32'h300);
        reset_init("ovf_clr");
        check("ovf_err_cleared", 32'(error), 32'd0);

        // Counter wrap after 32 pops on output 0.
        reset_init("wrap");
        for (int p = 0; p < 32; p++) begin
            send(1, 10'h0A0 + 10'(p));
            wait_nonempty(0, $sformatf("wrap%0d", p));
            pop(0);
            check($sformatf("wrap%0d_data", p), 32'(dout(0)), 32'h0A0 + 32'(p));
            if (p == 30) rd_cnt(2'd0, 5'd31, "wrap_cnt31");
        end
        rd_cnt(2'd0, 5'd0, "wrap_cnt0");

        // Asynchronous reset in the middle of an ACTIVE cycle.
        reset_init("arst");
        send(0, 10'h2A5);
        wait_nonempty(2, "arst_pre");
        pop(2);
        check("arst_pre_data", 32'(dout(2)), 32'h2A5);
        for (int i = 0; i < 4; i++) data_in[i*10 +: 10] = 10'h301 + 10'(i);
        push_in = 4'hF;
        cyc();
        push_in = 4'h0;
        cyc();
        check("arst_active", 32'(state), 32'd3);
        req = 1'b1;
        idx = 2'd2;
        cyc();
        req = 1'b0;
        check("arst_cnt_valid", 32'({cnt_valid, cnt_data}), 32'h21);
        #3;
        reset = 1'b1;
        #1;
        check_reset_vals("arst");
        cyc();
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
